// File: rtl/ddr3_odt_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ddr3_odt_seq
//  Purpose  : Fabric-side ODT sequencer for the DDR3 ODT pin. Turns write
//             command events into a 4-bit-per-fabric-cycle ODT pattern for a
//             4:1 output IOD, with CWL-derived turn-on timing and merging of
//             overlapping windows. Also sequences the IOD dynamic output
//             delay line (LOAD / MOVE / DIRECTION) from a request/ack
//             handshake.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: DDR3_ODT_STATS_EN
//      defined   -> WR_CMD_COUNT / MERGE_COUNT are saturating 16-bit counters
//      undefined -> both ports tied to zero, no counter logic
// ----------------------------------------------------------------------------
//  Ports
//      FAB_CLK                    in   fabric clock (1/4 DRAM clock)
//      TX_SYNC_RST                in   synchronous active-high reset
//      ODT_ENABLE                 in   accept write commands
//      WR_CMD_VALID               in   write command this cycle
//      WR_CMD_SLOT[1:0]           in   DRAM-clock slot of the command
//      ODT_FORCE                  in   drive ODT high on all slots
//      TX_DATA_0[3:0]             out  ODT pattern, bit0 = earliest clock
//      OE_DATA_0[3:0]             out  output enable per slot
//      ODT_ACTIVE                 out  window bits pending or being output
//      DL_REQ/DL_LOAD/DL_DIR      in   delay-line request and its options
//      DL_STEPS[5:0]              in   number of MOVE pulses
//      DL_BUSY/DL_ACK/DL_ERR      out  delay-line handshake status
//      DELAY_LINE_LOAD_0          out  to IOD
//      DELAY_LINE_MOVE_0          out  to IOD
//      DELAY_LINE_DIRECTION_0     out  to IOD
//      DELAY_LINE_OUT_OF_RANGE_0  in   from IOD
//      WR_CMD_COUNT[15:0]         out  accepted command count
//      MERGE_COUNT[15:0]          out  commands accepted while ODT active
// ============================================================================
module ddr3_odt_seq #(
    parameter int CWL       = 6,
    parameter int ODT_BURST = 6,
    parameter int DL_SETTLE = 4
) (
    input  logic        FAB_CLK,
    input  logic        TX_SYNC_RST,
    input  logic        ODT_ENABLE,
    input  logic        WR_CMD_VALID,
    input  logic [1:0]  WR_CMD_SLOT,
    input  logic        ODT_FORCE,
    output logic [3:0]  TX_DATA_0,
    output logic [3:0]  OE_DATA_0,
    output logic        ODT_ACTIVE,
    input  logic        DL_REQ,
    input  logic        DL_LOAD,
    input  logic        DL_DIR,
    input  logic [5:0]  DL_STEPS,
    output logic        DL_BUSY,
    output logic        DL_ACK,
    output logic        DL_ERR,
    output logic        DELAY_LINE_LOAD_0,
    output logic        DELAY_LINE_MOVE_0,
    output logic        DELAY_LINE_DIRECTION_0,
    input  logic        DELAY_LINE_OUT_OF_RANGE_0,
    output logic [15:0] WR_CMD_COUNT,
    output logic [15:0] MERGE_COUNT
);

    // Window length rounded up to whole fabric cycles, with one spare cycle
    // so the farthest burst bit always fits.
    localparam int c_SR_W = ((CWL + ODT_BURST + 4 + 3) / 4) * 4;
    localparam logic [c_SR_W-1:0] c_BURST_ONES =
        {{(c_SR_W - ODT_BURST){1'b0}}, {ODT_BURST{1'b1}}};
    localparam logic [4:0] c_SHIFT_BASE = 5'(CWL - 2);
    localparam logic [3:0] c_GAP_LAST   = 4'(DL_SETTLE - 1);

    // ------------------------------------------------------------------
    // ODT window
    // ------------------------------------------------------------------
    // r_w bit k is DRAM clock k counted from slot 0 of the fabric cycle
    // after the current one. A command's mask is merged before the low
    // nibble is peeled off, so the mask's bit 0 lands in TX_DATA_0 of the
    // very next cycle.
    logic [c_SR_W-1:0] r_w;
    logic [c_SR_W-1:0] w_mask;
    logic [c_SR_W-1:0] w_wfull;
    logic [3:0]        r_tx;
    logic [3:0]        r_oe;
    logic [4:0]        w_shift;
    logic              w_accept;
    logic              w_odt_active;

    always_comb begin
        w_accept = WR_CMD_VALID && ODT_ENABLE;
        w_shift  = {3'b000, WR_CMD_SLOT} + c_SHIFT_BASE;
        w_mask   = w_accept ? (c_BURST_ONES << w_shift) : '0;
        w_wfull  = r_w | w_mask;
    end

    always_ff @(posedge FAB_CLK) begin
        if (TX_SYNC_RST) begin
            r_w  <= '0;
            r_tx <= 4'b0000;
            r_oe <= 4'b0000;
        end else begin
            r_w  <= w_wfull >> 4;
            r_tx <= w_wfull[3:0] | {4{ODT_FORCE}};
            r_oe <= 4'b1111;
        end
    end

    assign w_odt_active = (|r_w) | (|r_tx);
    assign TX_DATA_0    = r_tx;
    assign OE_DATA_0    = r_oe;
    assign ODT_ACTIVE   = w_odt_active;

    // ------------------------------------------------------------------
    // Delay-line sequencer
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_STEP = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } dl_state_t;

    dl_state_t   r_state;
    dl_state_t   w_next;
    logic [5:0]  r_steps;
    logic [3:0]  r_gap;
    logic        r_dir;
    logic        r_err;
    logic        w_gap_last;

    always_comb begin
        w_next     = r_state;
        w_gap_last = (r_gap == 4'd0);
        case (r_state)
            S_IDLE: begin
                if (DL_REQ) begin
                    if (DL_LOAD)
                        w_next = S_LOAD;
                    else if (DL_STEPS == 6'd0)
                        w_next = S_DONE;
                    else
                        w_next = S_STEP;
                end
            end
            S_LOAD:  w_next = (r_steps == 6'd0) ? S_DONE : S_STEP;
            S_STEP:  w_next = S_GAP;
            S_GAP: begin
                if (w_gap_last) begin
                    // Out-of-range takes priority over remaining steps.
                    if (DELAY_LINE_OUT_OF_RANGE_0)
                        w_next = S_DONE;
                    else if (r_steps != 6'd0)
                        w_next = S_STEP;
                    else
                        w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (TX_SYNC_RST) begin
            r_state <= S_IDLE;
            r_steps <= 6'd0;
            r_gap   <= 4'd0;
            r_dir   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (DL_REQ) begin
                        r_dir   <= DL_DIR;
                        r_steps <= DL_STEPS;
                        r_err   <= 1'b0;
                    end
                end
                S_STEP: begin
                    r_steps <= r_steps - 6'd1;
                    r_gap   <= c_GAP_LAST;
                end
                S_GAP: begin
                    if (!w_gap_last)
                        r_gap <= r_gap - 4'd1;
                    else if (DELAY_LINE_OUT_OF_RANGE_0)
                        r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign DL_BUSY                = (r_state != S_IDLE);
    assign DL_ACK                 = (r_state == S_DONE);
    assign DL_ERR                 = (r_state == S_DONE) && r_err;
    assign DELAY_LINE_LOAD_0      = (r_state == S_LOAD);
    assign DELAY_LINE_MOVE_0      = (r_state == S_STEP);
    // Direction is only meaningful while a sequence is running.
    assign DELAY_LINE_DIRECTION_0 = (r_state != S_IDLE) && r_dir;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef DDR3_ODT_STATS_EN
    logic [15:0] r_wr_cnt;
    logic [15:0] r_merge_cnt;

    always_ff @(posedge FAB_CLK) begin
        if (TX_SYNC_RST) begin
            r_wr_cnt    <= 16'd0;
            r_merge_cnt <= 16'd0;
        end else if (w_accept) begin
            if (r_wr_cnt != 16'hFFFF)
                r_wr_cnt <= r_wr_cnt + 16'd1;
            if (w_odt_active && (r_merge_cnt != 16'hFFFF))
                r_merge_cnt <= r_merge_cnt + 16'd1;
        end
    end

    assign WR_CMD_COUNT = r_wr_cnt;
    assign MERGE_COUNT  = r_merge_cnt;
`else
    assign WR_CMD_COUNT = 16'd0;
    assign MERGE_COUNT  = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr3_odt_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr3_odt_seq
//  Purpose  : Self-checking bench for ddr3_odt_seq. Directed and random
//             stimulus; expected per-cycle outputs come from a timeline model
//             (absolute DRAM-clock bit array plus per-cycle delay-line event
//             arrays) and are queued for a separate monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_odt_seq;

    localparam int CWL       = 6;
    localparam int ODT_BURST = 6;
    localparam int DL_SETTLE = 4;
    localparam int NCYC      = 1200;

    logic        clk = 1'b0;
    logic        rst;
    logic        odt_en, wr_valid, odt_force;
    logic [1:0]  wr_slot;
    logic [3:0]  tx_data, oe_data;
    logic        odt_active;
    logic        dl_req, dl_load, dl_dir;
    logic [5:0]  dl_steps;
    logic        dl_busy, dl_ack, dl_err;
    logic        dly_load, dly_move, dly_dir, dly_oor;
    logic [15:0] wr_count, merge_count;

    always #5 clk = ~clk;

    ddr3_odt_seq #(
        .CWL       (CWL),
        .ODT_BURST (ODT_BURST),
        .DL_SETTLE (DL_SETTLE)
    ) dut (
        .FAB_CLK                   (clk),
        .TX_SYNC_RST               (rst),
        .ODT_ENABLE                (odt_en),
        .WR_CMD_VALID              (wr_valid),
        .WR_CMD_SLOT               (wr_slot),
        .ODT_FORCE                 (odt_force),
        .TX_DATA_0                 (tx_data),
        .OE_DATA_0                 (oe_data),
        .ODT_ACTIVE                (odt_active),
        .DL_REQ                    (dl_req),
        .DL_LOAD                   (dl_load),
        .DL_DIR                    (dl_dir),
        .DL_STEPS                  (dl_steps),
        .DL_BUSY                   (dl_busy),
        .DL_ACK                    (dl_ack),
        .DL_ERR                    (dl_err),
        .DELAY_LINE_LOAD_0         (dly_load),
        .DELAY_LINE_MOVE_0         (dly_move),
        .DELAY_LINE_DIRECTION_0    (dly_dir),
        .DELAY_LINE_OUT_OF_RANGE_0 (dly_oor),
        .WR_CMD_COUNT              (wr_count),
        .MERGE_COUNT               (merge_count)
    );

    typedef struct {
        int          cyc;
        logic [3:0]  tx;
        logic [3:0]  oe;
        logic        act;
        logic        load;
        logic        move;
        logic        dir;
        logic        busy;
        logic        ack;
        logic        err;
        logic [15:0] wrc;
        logic [15:0] mgc;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference timeline: ODT high per absolute DRAM clock, delay-line
    // outputs per absolute fabric cycle.
    bit e_odt  [0:8191];
    bit e_load [0:2047];
    bit e_move [0:2047];
    bit e_dir  [0:2047];
    bit e_busy [0:2047];
    bit e_ack  [0:2047];
    bit e_err  [0:2047];
    int oor_start = 1 << 30;
    int oor_end   = -1;
    int wr_cnt    = 0;
    int mg_cnt    = 0;
    bit cur_active = 1'b0;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, want);
        end
    endtask

    // Monitor: compares the DUT against the entry queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                compared++;
                mismatched++;
                $display("FAIL stale_entry cycle %0d: got none expected entry for %0d", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                chk("tx_data",    {12'd0, tx_data},     {12'd0, e.tx});
                chk("oe_data",    {12'd0, oe_data},     {12'd0, e.oe});
                chk("odt_active", {15'd0, odt_active},  {15'd0, e.act});
                chk("dl_load",    {15'd0, dly_load},    {15'd0, e.load});
                chk("dl_move",    {15'd0, dly_move},    {15'd0, e.move});
                chk("dl_dir",     {15'd0, dly_dir},     {15'd0, e.dir});
                chk("dl_busy",    {15'd0, dl_busy},     {15'd0, e.busy});
                chk("dl_ack",     {15'd0, dl_ack},      {15'd0, e.ack});
                chk("dl_err",     {15'd0, dl_err},      {15'd0, e.err});
                chk("wr_count",   wr_count,             e.wrc);
                chk("merge_count", merge_count,         e.mgc);
            end
        end
    end

    task automatic mark(input int t, input bit dr);
        e_busy[t] = 1'b1;
        e_dir[t]  = dr;
    endtask

    // Delay-line timeline for a request accepted in cycle r. k is the MOVE
    // after which the IOD reports out-of-range (0 or > st: never).
    task automatic plan_dl(input int r, input bit ld, input bit dr, input int st, input int k);
        int t;
        bit er;
        t  = r + 1;
        er = 1'b0;
        oor_start = 1 << 30;
        if (ld) begin
            e_load[t] = 1'b1;
            mark(t, dr);
            t++;
        end
        for (int i = 1; i <= st; i++) begin
            e_move[t] = 1'b1;
            for (int j = 0; j <= DL_SETTLE; j++) mark(t + j, dr);
            if (i == k) begin
                er        = 1'b1;
                oor_start = t + 1;
                t         = t + DL_SETTLE + 1;
                break;
            end
            t = t + DL_SETTLE + 1;
        end
        mark(t, dr);
        e_ack[t] = 1'b1;
        e_err[t] = er;
        oor_end  = t;
    endtask

    task automatic step(input int n);
        bit   r, v, en, f, rq, ld, dr, oor;
        int   s, st, k;
        exp_t e;
        r = (n < 4); v = 0; s = 0; en = 1; f = 0;
        rq = 0; ld = 0; dr = 0; st = 0; k = 0;
        if (n < 120 || (n >= 650 && n < 730)) begin
            case (n)
                10:      begin v = 1; s = 0; end
                20:      begin v = 1; s = 3; end
                30, 31:  v = 1;
                40, 42:  v = 1;
                50:      f = 1;
                55:      begin v = 1; en = 0; end
                60:      begin rq = 1; ld = 1; dr = 1; st = 3; end
                90:      begin rq = 1; ld = 1; dr = 1; st = 3; k = 2; end
                700:     begin rq = 1; ld = 1; dr = 1; st = 3; end
                702:     begin v = 1; s = 1; end
                705:     r = 1;
                707:     f = 1;
                default: ;
            endcase
        end else begin
            v  = ($urandom_range(0, 3) == 0);
            s  = $urandom_range(0, 3);
            en = ($urandom_range(0, 7) != 0);
            f  = ($urandom_range(0, 15) == 0);
            rq = ($urandom_range(0, 9) == 0);
            ld = ($urandom_range(0, 1) == 1);
            dr = ($urandom_range(0, 1) == 1);
            st = $urandom_range(0, 4);
            k  = $urandom_range(0, 4);
            r  = ($urandom_range(0, 199) == 0) || (n == 600);
        end
        if (e_busy[n])
            oor = (n >= oor_start) && (n <= oor_end);
        else
            oor = ($urandom_range(0, 1) == 1);

        rst       = r;
        wr_valid  = v;
        wr_slot   = 2'(s);
        odt_en    = en;
        odt_force = f;
        dl_req    = rq;
        dl_load   = ld;
        dl_dir    = dr;
        dl_steps  = 6'(st);
        dly_oor   = oor;

        if (r) begin
            for (int c = n + 1; c < n + 200; c++) begin
                e_load[c] = 0; e_move[c] = 0; e_dir[c] = 0;
                e_busy[c] = 0; e_ack[c]  = 0; e_err[c] = 0;
            end
            for (int b = 4 * (n + 1); b < 4 * (n + 1) + 64; b++) e_odt[b] = 0;
            wr_cnt = 0;
            mg_cnt = 0;
        end else begin
            if (v && en) begin
                for (int i = 0; i < ODT_BURST; i++) e_odt[4 * (n + 1) + s + CWL - 2 + i] = 1'b1;
                if (wr_cnt < 65535) wr_cnt++;
                if (cur_active && mg_cnt < 65535) mg_cnt++;
            end
            if (rq && !e_busy[n]) plan_dl(n, ld, dr, st, k);
        end

        e.cyc = n + 1;
        for (int j = 0; j < 4; j++) e.tx[j] = r ? 1'b0 : (e_odt[4 * (n + 1) + j] | f);
        e.oe  = r ? 4'h0 : 4'hF;
        e.act = |e.tx;
        for (int b = 4 * (n + 2); b < 4 * (n + 2) + 64; b++) if (e_odt[b]) e.act = 1'b1;
        e.load = e_load[n + 1];
        e.move = e_move[n + 1];
        e.dir  = e_dir[n + 1];
        e.busy = e_busy[n + 1];
        e.ack  = e_ack[n + 1];
        e.err  = e_err[n + 1];
`ifdef DDR3_ODT_STATS_EN
        e.wrc = 16'(wr_cnt);
        e.mgc = 16'(mg_cnt);
`else
        e.wrc = 16'd0;
        e.mgc = 16'd0;
`endif
        cur_active = e.act;
        q.push_back(e);
    endtask

    initial begin
        rst = 1; odt_en = 0; wr_valid = 0; wr_slot = 0; odt_force = 0;
        dl_req = 0; dl_load = 0; dl_dir = 0; dl_steps = 0; dly_oor = 0;
        for (int it = 0; it < NCYC; it++) begin
            @(posedge clk);
            #1;
            step(cyc);
        end
        repeat (3) @(negedge clk);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL queue_drain: got %0d entries left expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr3_odt_seq.md
Name: ddr3_odt_seq

Overview:
- Fabric-side ODT sequencer for the DDR3 ODT pin; sits directly upstream of the ODT pin's 4:1 output IOD.
- Converts controller write-command events into a per-fabric-cycle 4-bit ODT pattern (TX_DATA_0/OE_DATA_0) with CWL-derived ODTLon timing, merging overlapping windows.
- Also sequences the IOD's dynamic output delay line (LOAD/MOVE/DIRECTION) from a request/ack handshake.

Parameters:
- CWL, 6, DDR3 CAS write latency in DRAM clocks; legal 5..12.
- ODT_BURST, 6, ODT high duration in DRAM clocks per write; legal 4..16.
- DL_SETTLE, 4, FAB_CLK cycles idle after each MOVE pulse; legal 1..15.

Ports:
- FAB_CLK  in  1  fabric clock, 1/4 DRAM clock rate.
- TX_SYNC_RST  in  1  synchronous active-high reset.
- ODT_ENABLE  in  1  1 = accept write commands.
- WR_CMD_VALID  in  1  write command issued this cycle.
- WR_CMD_SLOT  in  2  DRAM-clock slot (0..3) of the command within this fabric cycle.
- ODT_FORCE  in  1  drive ODT high on all four slots.
- TX_DATA_0  out  4  ODT pattern; bit0 = earliest DRAM clock.
- OE_DATA_0  out  4  output enable per slot.
- ODT_ACTIVE  out  1  any window bit pending or being output.
- DL_REQ  in  1  delay-line request pulse.
- DL_LOAD  in  1  with DL_REQ: reload the default delay before stepping.
- DL_DIR  in  1  with DL_REQ: step direction.
- DL_STEPS  in  6  with DL_REQ: number of MOVE pulses.
- DL_BUSY  out  1  delay-line FSM not in IDLE.
- DL_ACK  out  1  one-cycle completion pulse.
- DL_ERR  out  1  valid with DL_ACK; 1 = aborted on out-of-range.
- DELAY_LINE_LOAD_0  out  1  to IOD.
- DELAY_LINE_MOVE_0  out  1  to IOD.
- DELAY_LINE_DIRECTION_0  out  1  to IOD.
- DELAY_LINE_OUT_OF_RANGE_0  in  1  from IOD.
- WR_CMD_COUNT  out  16  statistics, see Optional Feature.
- MERGE_COUNT  out  16  statistics, see Optional Feature.

Behaviour:
- Reset: every output is 0. The window shift register is cleared and the delay-line FSM goes to IDLE. Reset asserted mid-window or mid-step aborts with no DL_ACK.
- Window register W, SR_W bits, where SR_W = CWL+ODT_BURST+4 rounded up to a multiple of 4. Bit index k = DRAM clock k relative to slot 0 of the next fabric cycle.
- Each cycle:
  - TX_DATA_0 <= W[3:0] | {4{ODT_FORCE}}.
  - W <= (W >> 4) | mask.
  - mask has ones at k = WR_CMD_SLOT+CWL-2 .. WR_CMD_SLOT+CWL-2+ODT_BURST-1, applied only when WR_CMD_VALID && ODT_ENABLE.
- Latency:
  - Command in cycle n → first high bit at index slot+CWL-2 of the stream starting at TX_DATA_0 in cycle n+1.
  - ODT_FORCE has 1-cycle latency.
- Overlap: new masks OR into W, so back-to-back writes give continuous ODT. No shortening or extension beyond the union.
- ODT_ENABLE low: commands are ignored. Already-queued window bits drain normally.
- OE_DATA_0 is registered: 4'b1111 from the first cycle after reset release.
- ODT_ACTIVE = |W | (|TX_DATA_0).
- Delay-line FSM states: IDLE, LOAD, STEP, GAP, DONE.
  - IDLE: on DL_REQ, latch DIR and STEPS. Go to LOAD if DL_LOAD=1, else STEP; if STEPS=0, go to DONE.
  - LOAD: DELAY_LINE_LOAD_0 = 1 for one cycle. Then STEP, or DONE if STEPS=0.
  - STEP: DELAY_LINE_MOVE_0 = 1 for one cycle; decrement the step counter; go to GAP.
  - GAP: wait DL_SETTLE cycles. On the last GAP cycle:
    - OUT_OF_RANGE=1 → DONE with error.
    - else remaining steps > 0 → STEP.
    - else → DONE.
  - DONE: DL_ACK = 1 for one cycle, DL_ERR as determined; then IDLE.
- DELAY_LINE_DIRECTION_0 holds the latched DIR from LOAD through DONE. It is 0 in IDLE.
- DL_BUSY = 1 in every state except IDLE. DL_REQ while busy is ignored.

Optional Feature:
- Macro: DDR3_ODT_STATS_EN.
- Defined:
  - WR_CMD_COUNT increments per accepted command.
  - MERGE_COUNT increments per accepted command arriving while ODT_ACTIVE=1.
  - Both counters are 16-bit, saturate at 16'hFFFF, and clear on reset.
- Undefined: both ports remain present and are tied to 0; no counter logic is generated.

Test Plan:
- CWL=6, ODT_BURST=6; command at cycle 10, slot 0 → TX_DATA_0 = 0000 at 11, 1111 at 12, 0011 at 13, 0000 at 14.
- Command at cycle 10, slot 3 → 1000 at 12, 1111 at 13, 0001 at 14.
- Commands at cycle 10 slot 0 and cycle 11 slot 0 → 1111 at 12, 1111 at 13, 0011 at 14; MERGE_COUNT=1 with DDR3_ODT_STATS_EN.
- Commands at cycle 10 slot 0 and cycle 12 slot 0 → 1111 at 12, 0011 at 13, 1111 at 14, 0011 at 15.
- DL_REQ with LOAD=1, DIR=1, STEPS=3, DL_SETTLE=4 → LOAD pulse, then 3 MOVE pulses 5 cycles apart, DIRECTION=1 throughout, DL_ACK with ERR=0. Repeat with OUT_OF_RANGE=1 after the 2nd MOVE → only 2 MOVEs, DL_ACK with ERR=1.
- TX_SYNC_RST asserted during an active window and during GAP → next cycle all outputs 0 and no DL_ACK; ODT_FORCE=1 after release → 1111 one cycle later.
